// File: rtl/hier_leaf_fifo_stage.sv
// -----------------------------------------------------------------------------
// hier_leaf_fifo_stage
//
// Purpose
//   Leaf buffering stage that sits under one hierarchy node. Words arrive from
//   the parent on a valid/ready port, are held in a small FIFO, and leave on a
//   valid/ready port towards the next leaf. Occupancy is reported on level_o.
//   A sticky error flag records an input stall that lasts 16 cycles.
//
// Handshake
//   A word moves on a port in every cycle where valid and ready are both high
//   at the rising clock edge. A producer holds valid and data steady until the
//   word is taken. Ready never depends combinationally on valid on either port.
//
// Ports
//   clk        in   1              rising-edge clock
//   rst_n      in   1              asynchronous active-low reset
//   in_valid   in   1              upstream word valid
//   in_data    in   DATA_W         upstream word
//   in_ready   out  1              stage can accept (not full)
//   out_valid  out  1              head word valid (not empty)
//   out_data   out  DATA_W         head word, read from the storage registers
//   out_ready  in   1              downstream accepts
//   level_o    out  $clog2(DEPTH)+1  occupancy 0..DEPTH
//   err_o      out  1              sticky error flag
//   id_o       out  4              constant INST_ID
//
// Build option
//   HIER_LEAF_PARITY_EN : when defined, every entry carries an even-parity bit
//   written on push and rechecked on pop; a mismatch sets err_o. The port list
//   is the same in both builds.
// -----------------------------------------------------------------------------
module hier_leaf_fifo_stage #(
    parameter int DATA_W  = 8,
    parameter int DEPTH   = 4,
    parameter int INST_ID = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    input  logic [DATA_W-1:0]          in_data,
    output logic                       in_ready,
    output logic                       out_valid,
    output logic [DATA_W-1:0]          out_data,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     level_o,
    output logic                       err_o,
    output logic [3:0]                 id_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);
    localparam logic [4:0]       WD_LIMIT = 5'd16;

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_PARTIAL = 2'd1,
        ST_FULL    = 2'd2
    } ctrl_t;

    // Storage and control state
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [LVL_W-1:0]  r_level;
    ctrl_t             r_ctrl_q;
    logic [4:0]        r_wd_cnt;
    logic              r_err;

    // Combinational helpers
    ctrl_t             w_ctrl_next;
    logic [LVL_W-1:0]  w_level_next;
    logic [4:0]        w_wd_next;
    logic              w_in_ready;
    logic              w_out_valid;
    logic              w_push;
    logic              w_pop;
    logic              w_stall;
    logic              w_par_err;

    // Flags come straight from the control state, so a pop in a FULL cycle
    // cannot reopen in_ready until the state register has moved on.
    assign w_in_ready  = (r_ctrl_q != ST_FULL);
    assign w_out_valid = (r_ctrl_q != ST_EMPTY);
    assign w_push      = in_valid & w_in_ready;
    assign w_pop       = w_out_valid & out_ready;
    assign w_stall     = in_valid & ~w_in_ready;

    assign in_ready  = w_in_ready;
    assign out_valid = w_out_valid;
    assign out_data  = r_mem[r_rd_ptr];
    assign level_o   = (r_ctrl_q == ST_EMPTY) ? '0 : r_level;
    assign err_o     = r_err;
    assign id_o      = 4'(INST_ID);

    // Next level and next control state
    always_comb begin
        w_level_next = r_level;
        w_ctrl_next  = r_ctrl_q;
        case ({w_push, w_pop})
            2'b10:   w_level_next = r_level + LVL_W'(1);
            2'b01:   w_level_next = r_level - LVL_W'(1);
            default: w_level_next = r_level;
        endcase
        case (r_ctrl_q)
            ST_EMPTY: begin
                if (w_push) begin
                    w_ctrl_next = ST_PARTIAL;
                end
            end
            ST_PARTIAL: begin
                if (w_level_next == LVL_FULL) begin
                    w_ctrl_next = ST_FULL;
                end else if (w_level_next == '0) begin
                    w_ctrl_next = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (w_pop) begin
                    w_ctrl_next = ST_PARTIAL;
                end
            end
            default: w_ctrl_next = ST_EMPTY;
        endcase
    end

    // Stall watchdog: counts cycles with a refused push, saturating at 16.
    // Only an accepted push clears it; an idle input leaves it unchanged.
    always_comb begin
        w_wd_next = r_wd_cnt;
        if (w_push) begin
            w_wd_next = '0;
        end else if (w_stall && (r_wd_cnt != WD_LIMIT)) begin
            w_wd_next = r_wd_cnt + 5'd1;
        end
    end

`ifdef HIER_LEAF_PARITY_EN
    logic r_par [DEPTH];

    assign w_par_err = w_pop & ((^r_mem[r_rd_ptr]) != r_par[r_rd_ptr]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_par[i] <= 1'b0;
            end
        end else if (w_push) begin
            r_par[r_wr_ptr] <= ^in_data;
        end
    end
`else
    assign w_par_err = 1'b0;
`endif

    // Control state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ctrl_q <= ST_EMPTY;
            r_level  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_wd_cnt <= '0;
            r_err    <= 1'b0;
        end else begin
            r_ctrl_q <= w_ctrl_next;
            r_level  <= w_level_next;
            r_wd_cnt <= w_wd_next;
            r_err    <= r_err | (w_wd_next == WD_LIMIT) | w_par_err;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
        end
    end

    // Storage array; cleared on reset so out_data reads zero afterwards
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

endmodule

// File: tb/tb_hier_leaf_fifo_stage.sv
module tb_hier_leaf_fifo_stage;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;
  localparam int LVL_W  = $clog2(DEPTH) + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              in_valid = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready = 1'b0;
  logic [LVL_W-1:0]  level_o;
  logic              err_o;
  logic [3:0]        id_o;

  hier_leaf_fifo_stage #(.DATA_W(DATA_W), .DEPTH(DEPTH), .INST_ID(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .level_o(level_o), .err_o(err_o), .id_o(id_o)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // FIFO content as a queue; readiness is "fewer than DEPTH words held",
  // evaluated from the contents before the edge.
  logic [DATA_W-1:0] exp_q[$];
  int m_wd = 0;
  bit m_err = 0;
  bit chk_en = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      m_wd = 0;
      m_err = 0;
    end else begin
      bit can_in, do_push, do_pop;
      can_in  = exp_q.size() < DEPTH;
      do_push = in_valid && can_in;
      do_pop  = out_ready && exp_q.size() > 0;
      if (do_pop) void'(exp_q.pop_front());
      if (do_push) exp_q.push_back(in_data);
      if (do_push) m_wd = 0;
      else if (in_valid && !can_in && m_wd < 16) m_wd = m_wd + 1;
      if (m_wd == 16) m_err = 1;
    end
  end

  // Compare process: every falling edge once enabled
  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready", 32'(in_ready), 32'(exp_q.size() < DEPTH));
      chk("out_valid", 32'(out_valid), 32'(exp_q.size() > 0));
      chk("level", 32'(level_o), 32'(exp_q.size()));
      chk("err", 32'(err_o), 32'(m_err));
      chk("id", 32'(id_o), 32'd3);
      if (exp_q.size() > 0) chk("out_data", 32'(out_data), 32'(exp_q[0]));
    end
  end

  // ---------------- driver ----------------
  // Inputs change 1 time unit after a rising edge, then one edge is consumed.
  task automatic drive(input bit iv, input logic [DATA_W-1:0] d, input bit ordy);
    in_valid  = iv;
    in_data   = iv ? d : DATA_W'($urandom_range(0, 255));
    out_ready = ordy;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  logic [DATA_W-1:0] vec [6];

  initial begin
    // 1. reset with in_valid high
    in_valid = 1'b1;
    in_data  = 8'h55;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_level", 32'(level_o), 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
    in_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_en = 1;

    // 2. single word
    drive(1, 8'hA5, 0);
    chk("single_valid", 32'(out_valid), 32'd1);
    chk("single_data", 32'(out_data), 32'hA5);
    chk("single_level", 32'(level_o), 32'd1);
    drive(0, 8'h00, 1);
    chk("single_pop_level", 32'(level_o), 32'd0);
    chk("single_pop_valid", 32'(out_valid), 32'd0);

    // 3. fill then drain in order
    for (int i = 1; i <= 4; i++) drive(1, DATA_W'(i), 0);
    chk("fill_ready", 32'(in_ready), 32'd0);
    chk("fill_level", 32'(level_o), 32'd4);
    for (int i = 1; i <= 4; i++) begin
      chk("drain_data", 32'(out_data), 32'(i));
      drive(0, 8'h00, 1);
    end
    chk("drain_level", 32'(level_o), 32'd0);

    // 4. full, then push and pop together for 20 cycles; pointers wrap
    for (int i = 0; i < 4; i++) drive(1, DATA_W'(8'h10 + i), 0);
    for (int i = 0; i < 20; i++) drive(1, DATA_W'(8'h20 + i), 1);
    // first cycle only pops (full), afterwards push+pop keeps level at 3
    chk("stream_level", 32'(level_o), 32'd3);
    chk("stream_head", 32'(out_data), 32'h31);
    for (int i = 0; i < 3; i++) drive(0, 8'h00, 1);
    chk("stream_empty", 32'(level_o), 32'd0);

    // mixed directed vectors
    vec = '{8'h3C, 8'hC3, 8'h00, 8'hFF, 8'h81, 8'h7E};
    for (int i = 0; i < 6; i++) drive(1, vec[i], i[0]);
    for (int i = 0; i < 6; i++) drive(0, 8'h00, 1);
    chk("mixed_empty", 32'(level_o), 32'd0);

    // 5. stall watchdog
    for (int i = 0; i < 4; i++) drive(1, DATA_W'(8'h40 + i), 0);
    for (int i = 0; i < 15; i++) drive(1, 8'h99, 0);
    chk("wd_15_err", 32'(err_o), 32'd0);
    drive(1, 8'h99, 0);
    chk("wd_16_err", 32'(err_o), 32'd1);
    for (int i = 0; i < 5; i++) drive(0, 8'h00, 1);
    chk("wd_sticky", 32'(err_o), 32'd1);
    chk("wd_drained", 32'(level_o), 32'd0);

    // 6. reset mid-stream at level 3
    for (int i = 0; i < 3; i++) drive(1, DATA_W'(8'h60 + i), 0);
    chk("mid_level3", 32'(level_o), 32'd3);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_level", 32'(level_o), 32'd0);
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_err", 32'(err_o), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(1, 8'h5A, 0);
    chk("post_rst_data", 32'(out_data), 32'h5A);
    drive(0, 8'h00, 1);
    drive(0, 8'h00, 0);

    chk_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time bound
  initial begin
    #200000;
    bad++;
    $display("FAIL timeout: got no finish expected finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
